// File: rtl/axi_ddr3_slave_model.sv
// AXI4 slave responder standing in for the DDR3 controller's 128-bit port.
// Independent single-outstanding write and read FSMs over a byte-maskable word array.
module axi_ddr3_slave_model #(
  parameter int MEM_AW = 10,
  parameter int RD_GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   awid,
  input  logic [31:0]  awaddr,
  input  logic [7:0]   awlen,
  input  logic [2:0]   awsize,
  input  logic [1:0]   awburst,
  input  logic         awvalid,
  output logic         awready,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic         wlast,
  input  logic         wvalid,
  output logic         wready,
  output logic [7:0]   bid,
  output logic [1:0]   bresp,
  output logic         bvalid,
  input  logic         bready,
  input  logic [7:0]   arid,
  input  logic [31:0]  araddr,
  input  logic [7:0]   arlen,
  input  logic [2:0]   arsize,
  input  logic [1:0]   arburst,
  input  logic         arvalid,
  output logic         arready,
  output logic [7:0]   rid,
  output logic [127:0] rdata,
  output logic [1:0]   rresp,
  output logic         rlast,
  output logic         rvalid,
  input  logic         rready,
  output logic         wlast_err
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  logic [127:0] mem_q [DEPTH];

  w_state_e          w_state_q;
  logic [MEM_AW-1:0] w_ptr_q;
  logic [7:0]        w_len_q, w_cnt_q, bid_q;
  logic              awready_q, wready_q, bvalid_q, wlast_err_q;
  logic              w_fire;

  r_state_e          r_state_q;
  logic [MEM_AW-1:0] r_ptr_q, r_ptr_d;
  logic [7:0]        r_len_q, r_cnt_q, rid_q;
  logic [3:0]        gap_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [127:0]      rdata_q;

  // Burst type, size and address bits outside the word index are don't-care.
  logic unused_ok;
  assign unused_ok = ^{awaddr, araddr, awsize, arsize, awburst, arburst};

  assign w_fire  = (w_state_q == W_DATA) && wready_q && wvalid && !rst;
  assign r_ptr_d = r_ptr_q + MEM_AW'(1);

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int i = 0; i < 16; i++) begin
        if (wstrb[i]) mem_q[w_ptr_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      wlast_err_q <= 1'b0;
      w_ptr_q     <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_ptr_q   <= awaddr[MEM_AW+3:4];
            w_len_q   <= awlen;
            w_cnt_q   <= '0;
            bid_q     <= awid;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid && wready_q) begin
            if (wlast != (w_cnt_q == w_len_q)) wlast_err_q <= 1'b1;
            w_ptr_q <= w_ptr_q + MEM_AW'(1);
            w_cnt_q <= w_cnt_q + 8'd1;
            if (w_cnt_q == w_len_q) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready && bvalid_q) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Reads sample the array before any same-edge write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      r_ptr_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      gap_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            r_ptr_q   <= araddr[MEM_AW+3:4];
            r_len_q   <= arlen;
            r_cnt_q   <= '0;
            rid_q     <= arid;
            gap_q     <= '0;
            r_state_q <= R_WAIT;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (gap_q == 4'(RD_GAP)) begin
            rdata_q   <= mem_q[r_ptr_q];
            rvalid_q  <= 1'b1;
            rlast_q   <= (r_len_q == 8'd0);
            r_state_q <= R_DATA;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        R_DATA: begin
          if (rvalid_q && rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_ptr_q <= r_ptr_d;
              r_cnt_q <= r_cnt_q + 8'd1;
              rdata_q <= mem_q[r_ptr_d];
              rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = 2'b00;
  assign wlast_err = wlast_err_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rdata     = rdata_q;
  assign rid       = rid_q;
  assign rresp     = 2'b00;

endmodule

// File: tb/tb_axi_ddr3_slave_model.sv
// Scoreboard bench for axi_ddr3_slave_model: stimulus pushes expected B/R
// responses into queues, a negedge monitor pops and compares them.
module tb_axi_ddr3_slave_model;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   awid = '0, arid = '0, bid, rid;
  logic [31:0]  awaddr = '0, araddr = '0;
  logic [7:0]   awlen = '0, arlen = '0;
  logic [2:0]   awsize = 3'd4, arsize = 3'd4;
  logic [1:0]   awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic         awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
  logic         bvalid, bready = 1'b1, arvalid = 1'b0, arready;
  logic         rvalid, rready = 1'b1, rlast, wlast_err;
  logic [127:0] wdata = '0, rdata;
  logic [15:0]  wstrb = '0;

  typedef struct packed {
    logic [7:0]   id;
    logic         last;
    logic [127:0] data;
  } rexp_t;

  rexp_t        rq[$];
  logic [7:0]   bq[$];
  logic [127:0] model [1024];
  logic [127:0] wbuf  [256];
  int           errors = 0;
  int           checks = 0;
  bit           mon_en = 1'b1;
  bit           rr_toggle = 1'b0;

  axi_ddr3_slave_model #(.MEM_AW(10), .RD_GAP(0)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 rready = rr_toggle ? ~rready : 1'b1;
  end

  // Response monitor
  initial begin
    rexp_t      e;
    logic [7:0] eb;
    bit         stall = 1'b0;
    logic [127:0] pd = '0;
    logic       pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        stall = 1'b0;
      end else begin
        if (stall && rvalid) begin
          chk("r_stall_data", rdata, pd);
          chk("r_stall_last", rlast, pl);
        end
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected: got beat %h expected none", rdata);
          end else begin
            e = rq.pop_front();
            chk("r_data", rdata, e.data);
            chk("r_last", rlast, e.last);
            chk("r_id", rid, e.id);
            chk("r_resp", rresp, 2'b00);
          end
        end
        stall = rvalid && !rready;
        pd = rdata;
        pl = rlast;
        if (bvalid && bready) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got bid %h expected none", bid);
          end else begin
            eb = bq.pop_front();
            chk("b_id", bid, eb);
            chk("b_resp", bresp, 2'b00);
          end
        end
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input int len, input logic [7:0] id,
                    input logic [15:0] strb, input int bad_beat, input bit wait_b);
    int idx, n;
    idx = int'(addr[13:4]);
    @(posedge clk); #1;
    awaddr = addr; awlen = 8'(len); awid = id; awvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    chk("aw_accept", awready, 1'b1);
    bq.push_back(id);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wdata = wbuf[k]; wstrb = strb; wvalid = 1'b1;
      wlast = (bad_beat >= 0) ? (k == bad_beat) : (k == len);
      n = 0; @(negedge clk);
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (!wready) begin
        chk("w_accept", wready, 1'b1);
        break;
      end
      for (int b = 0; b < 16; b++)
        if (strb[b]) model[(idx + k) % 1024][8*b +: 8] = wbuf[k][8*b +: 8];
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("b_latency", bvalid, 1'b1);
    if (wait_b) begin
      n = 0;
      while (bvalid && n < 100) begin @(negedge clk); n++; end
      chk("b_done", bvalid, 1'b0);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input int len, input logic [7:0] id);
    int idx, n;
    rexp_t e;
    idx = int'(addr[13:4]);
    @(posedge clk); #1;
    araddr = addr; arlen = 8'(len); arid = id; arvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_accept", arready, 1'b1);
    for (int k = 0; k <= len; k++) begin
      e.id = id; e.last = (k == len); e.data = model[(idx + k) % 1024];
      rq.push_back(e);
    end
    @(posedge clk); #1 arvalid = 1'b0;
    n = 1; @(negedge clk);
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    chk("r_latency", n, 2);
    n = 0;
    while (rq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("r_drain", rq.size(), 0);
    n = 0;
    while (!arready && n < 10) begin @(negedge clk); n++; end
    chk("ar_return", n, 1);
  endtask

  task automatic release_reset();
    @(posedge clk); @(negedge clk);
    chk("rst_outputs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rlast,
                        rid, rdata, rresp, wlast_err}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_before", {awready, arready}, 2'b00);
    @(negedge clk);
    chk("rdy_after", {awready, arready}, 2'b11);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    for (int i = 0; i < 1024; i++) dut.mem_q[i] = '0;
    release_reset();

    // single beat
    wbuf[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    wr(32'h40, 0, 8'h11, 16'hFFFF, -1, 1'b1);
    rd(32'h40, 0, 8'h22);

    // 256-beat burst with rready toggling
    for (int k = 0; k < 256; k++) wbuf[k] = 128'(k);
    wr(32'h1000, 255, 8'h33, 16'hFFFF, -1, 1'b1);
    rr_toggle = 1'b1;
    rd(32'h1000, 255, 8'h44);
    rr_toggle = 1'b0;

    // strobes: bytes 4..7 cleared
    wbuf[0] = '1;
    wr(32'h200, 0, 8'h01, 16'hFFFF, -1, 1'b1);
    wbuf[0] = '0;
    wr(32'h200, 0, 8'h02, 16'h00F0, -1, 1'b1);
    chk("strobe_model", model[32], 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
    rd(32'h200, 0, 8'h03);

    // wrap at top of array, plus alias of 0x4000 onto word 0
    for (int k = 0; k < 4; k++) wbuf[k] = 128'hA000 + 128'(k);
    wr(32'h3FE0, 3, 8'h05, 16'hFFFF, -1, 1'b1);
    rd(32'h4000, 1, 8'h06);
    rd(32'h3FE0, 1, 8'h07);

    // wlast early on beat 1 of 4
    chk("wlast_err_clear", wlast_err, 1'b0);
    for (int k = 0; k < 4; k++) wbuf[k] = 128'hC0 + 128'(k);
    wr(32'h600, 3, 8'h08, 16'hFFFF, 1, 1'b1);
    chk("wlast_err_set", wlast_err, 1'b1);
    rd(32'h600, 3, 8'h09);

    // bready held low for 10 cycles
    bready = 1'b0;
    wbuf[0] = 128'hDEAD;
    wr(32'h900, 0, 8'h0A, 16'hFFFF, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b_hold_valid", bvalid, 1'b1);
      chk("b_hold_awready", awready, 1'b0);
    end
    @(posedge clk); #1 bready = 1'b1;
    n = 0; @(negedge clk);
    while (!awready && n < 10) begin @(negedge clk); n++; end
    chk("aw_after_b", n, 1);

    // concurrent AW/AR to one word: read sees old value
    wbuf[0] = 128'hAAAA;
    wr(32'h800, 0, 8'h0B, 16'hFFFF, -1, 1'b1);
    wbuf[0] = 128'hBBBB;
    fork
      wr(32'h800, 0, 8'h0C, 16'hFFFF, -1, 1'b1);
      rd(32'h800, 0, 8'h0D);
    join
    rd(32'h800, 0, 8'h0E);

    // reset in the middle of a read burst
    mon_en = 1'b0;
    @(posedge clk); #1 araddr = 32'h1000; arlen = 8'd15; arid = 8'h0F; arvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_accept_rst", arready, 1'b1);
    @(posedge clk); #1 arvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    release_reset();
    mon_en = 1'b1;
    rd(32'h40, 0, 8'h10);

    chk("queues_empty", {32'(rq.size()), 32'(bq.size())}, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
